// File: rtl/scr1_ahb_mem_slave_if.sv
// Bus bundle between an AHB-Lite master and the scr1_ahb_mem_slave, and
// between that slave and the SCR1-style memory behind it.
// Modports: slave = the bridge view; master = the bus/memory environment view.
interface scr1_ahb_mem_slave_if;
    // AHB-Lite side
    logic        hsel;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic        hready;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;
    // SCR1 memory side
    logic        mem_req;
    logic        mem_req_ack;
    logic        mem_cmd;
    logic [1:0]  mem_width;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [1:0]  mem_resp;

    modport slave (
        input  hsel, htrans, hwrite, hsize, haddr, hwdata, hready,
        output hreadyout, hresp, hrdata,
        output mem_req, mem_cmd, mem_width, mem_addr, mem_wdata,
        input  mem_req_ack, mem_rdata, mem_resp
    );

    modport master (
        output hsel, htrans, hwrite, hsize, haddr, hwdata, hready,
        input  hreadyout, hresp, hrdata,
        input  mem_req, mem_cmd, mem_width, mem_addr, mem_wdata,
        output mem_req_ack, mem_rdata, mem_resp
    );
endinterface

// File: rtl/scr1_ahb_mem_slave.sv
// AHB-Lite slave that turns each accepted transfer into one SCR1 memory request.
// Latency: 2 wait states minimum (REQ, RESP), data phase completes in DONE.
// Backpressure: hreadyout low while waiting on mem_req_ack / mem_resp; ERROR is two cycles.
// Ports: clk, rst_n (async, active low); bus = AHB-Lite + memory signals (slave modport).
module scr1_ahb_mem_slave #(
    parameter int SCR1_AHB_WIDTH  = 32,
    parameter bit ERR_ON_MISALIGN = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    scr1_ahb_mem_slave_if.slave    bus
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_REQ  = 3'd1;
    localparam logic [2:0] ST_RESP = 3'd2;
    localparam logic [2:0] ST_DONE = 3'd3;
    localparam logic [2:0] ST_ERR1 = 3'd4;
    localparam logic [2:0] ST_ERR2 = 3'd5;

    localparam logic [1:0] RESP_RDY_OK = 2'b01;

    logic [2:0]                state;
    logic [2:0]                state_nxt;
    logic [SCR1_AHB_WIDTH-1:0] addr_q;
    logic [SCR1_AHB_WIDTH-1:0] rdata_q;
    logic                      write_q;
    // Only the low two size bits are kept: oversized transfers never reach REQ.
    logic [1:0]                size_q;
    logic                      acc_win;
    logic                      acc;
    logic                      bad;
    logic                      misalign;
    logic                      unused_bits;

    // htrans[0] only separates NONSEQ from SEQ, which are handled identically.
    assign unused_bits = bus.htrans[0];

    // Address phase is only sampled in the cycles where hreadyout is high.
    assign acc_win  = (state == ST_IDLE) | (state == ST_DONE) | (state == ST_ERR2);
    assign acc      = acc_win & bus.hsel & bus.hready & bus.htrans[1];
    assign misalign = ((bus.hsize == 3'b001) & bus.haddr[0]) |
                      ((bus.hsize == 3'b010) & (bus.haddr[1:0] != 2'b00));
    assign bad      = (bus.hsize > 3'b010) | (ERR_ON_MISALIGN & misalign);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR2: begin
                if (acc) state_nxt = bad ? ST_ERR1 : ST_REQ;
                else     state_nxt = ST_IDLE;
            end
            ST_REQ:  if (bus.mem_req_ack) state_nxt = ST_RESP;
            ST_RESP: begin
                if (bus.mem_resp == RESP_RDY_OK) state_nxt = ST_DONE;
                // RDY_ER and the undefined code 11 are both errors.
                else if (bus.mem_resp[1])        state_nxt = ST_ERR1;
            end
            ST_ERR1: state_nxt = ST_ERR2;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= 2'b00;
            rdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (acc) begin
                addr_q  <= bus.haddr;
                write_q <= bus.hwrite;
                size_q  <= bus.hsize[1:0];
            end
            if ((state == ST_RESP) && (bus.mem_resp == RESP_RDY_OK) && !write_q) begin
                rdata_q <= bus.mem_rdata;
            end
        end
    end

    // All outputs decode straight from state, so reset forces them at once.
    assign bus.hreadyout = acc_win;
    assign bus.hresp     = (state == ST_ERR1) | (state == ST_ERR2);
    assign bus.hrdata    = rdata_q;
    assign bus.mem_req   = (state == ST_REQ);
    assign bus.mem_cmd   = write_q;
    assign bus.mem_width = size_q;
    assign bus.mem_addr  = addr_q;
    // Master holds hwdata through the wait states, so no capture is needed.
    assign bus.mem_wdata = bus.hwdata;

endmodule

// File: tb/tb_scr1_ahb_mem_slave.sv
module tb_scr1_ahb_mem_slave;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    scr1_ahb_mem_slave_if bus ();
    scr1_ahb_mem_slave_if bus2 ();

    // Single slave on each bus: bus-level HREADY is this slave's HREADYOUT.
    assign bus.hready  = bus.hreadyout;
    assign bus2.hready = bus2.hreadyout;

    scr1_ahb_mem_slave #(.SCR1_AHB_WIDTH(32), .ERR_ON_MISALIGN(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    scr1_ahb_mem_slave #(.SCR1_AHB_WIDTH(32), .ERR_ON_MISALIGN(1'b0)) dut_nomis (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ahb(input logic sel, input logic [1:0] trans, input logic wr,
                       input logic [2:0] size, input logic [31:0] addr);
        bus.hsel   = sel;
        bus.htrans = trans;
        bus.hwrite = wr;
        bus.hsize  = size;
        bus.haddr  = addr;
    endtask

    task automatic mem(input logic ack, input logic [1:0] resp, input logic [31:0] rdata);
        bus.mem_req_ack = ack;
        bus.mem_resp    = resp;
        bus.mem_rdata   = rdata;
    endtask

    task automatic ahb_idle();
        ahb(1'b0, 2'b00, 1'b0, 3'b000, 32'h0);
    endtask

    initial begin
        logic [31:0] b2b_data [3];
        b2b_data[0] = 32'hA0A0_0000;
        b2b_data[1] = 32'hB1B1_1111;
        b2b_data[2] = 32'hC2C2_2222;

        rst_n = 1'b0;
        ahb_idle();
        bus.hwdata = 32'h0;
        mem(1'b0, 2'b00, 32'h0);
        bus2.hsel = 1'b0; bus2.htrans = 2'b00; bus2.hwrite = 1'b0;
        bus2.hsize = 3'b000; bus2.haddr = 32'h0; bus2.hwdata = 32'h0;
        bus2.mem_req_ack = 1'b0; bus2.mem_resp = 2'b00; bus2.mem_rdata = 32'h0;
        repeat (2) step();
        chk("rst_hreadyout", {31'd0, bus.hreadyout}, 32'd1);
        chk("rst_hresp",     {31'd0, bus.hresp},     32'd0);
        chk("rst_hrdata",    bus.hrdata,             32'h0);
        chk("rst_mem_req",   {31'd0, bus.mem_req},   32'd0);
        rst_n = 1'b1;
        step();

        // ---- word read 0x100 ----
        ahb(1'b1, 2'b10, 1'b0, 3'b010, 32'h100);
        step();
        ahb_idle(); mem(1'b1, 2'b00, 32'h0); #1;
        chk("rd_req",    {31'd0, bus.mem_req},   32'd1);
        chk("rd_addr",   bus.mem_addr,           32'h100);
        chk("rd_cmd",    {31'd0, bus.mem_cmd},   32'd0);
        chk("rd_width",  {30'd0, bus.mem_width}, 32'd2);
        chk("rd_hrdy1",  {31'd0, bus.hreadyout}, 32'd0);
        step();
        mem(1'b0, 2'b01, 32'hDEADBEEF); #1;
        chk("rd_req_off", {31'd0, bus.mem_req},  32'd0);
        chk("rd_hrdy2",  {31'd0, bus.hreadyout}, 32'd0);
        step();
        mem(1'b0, 2'b00, 32'h0); #1;
        chk("rd_done_hrdy", {31'd0, bus.hreadyout}, 32'd1);
        chk("rd_done_hresp", {31'd0, bus.hresp},    32'd0);
        chk("rd_hrdata", bus.hrdata, 32'hDEADBEEF);
        step();

        // ---- byte write 0x203 with 3-cycle ack stall ----
        ahb(1'b1, 2'b10, 1'b1, 3'b000, 32'h203);
        step();
        ahb_idle(); bus.hwdata = 32'h0000_00A5;
        for (int i = 0; i < 4; i++) begin
            mem((i == 3), 2'b00, 32'h0); #1;
            chk($sformatf("wr_req_%0d", i),   {31'd0, bus.mem_req},   32'd1);
            chk($sformatf("wr_addr_%0d", i),  bus.mem_addr,           32'h203);
            chk($sformatf("wr_width_%0d", i), {30'd0, bus.mem_width}, 32'd0);
            chk($sformatf("wr_cmd_%0d", i),   {31'd0, bus.mem_cmd},   32'd1);
            chk($sformatf("wr_wdata_%0d", i), bus.mem_wdata,          32'hA5);
            step();
        end
        mem(1'b0, 2'b01, 32'h1234_5678); #1;
        chk("wr_resp_req", {31'd0, bus.mem_req}, 32'd0);
        step();
        mem(1'b0, 2'b00, 32'h0); #1;
        chk("wr_done_hrdy",  {31'd0, bus.hreadyout}, 32'd1);
        chk("wr_done_hresp", {31'd0, bus.hresp},     32'd0);
        chk("wr_hrdata_held", bus.hrdata, 32'hDEADBEEF);
        step();
        bus.hwdata = 32'h0;

        // ---- misaligned word 0x102, ERR_ON_MISALIGN = 1 ----
        ahb(1'b1, 2'b10, 1'b0, 3'b010, 32'h102);
        step();
        ahb_idle(); #1;
        chk("mis_err1_req",   {31'd0, bus.mem_req},   32'd0);
        chk("mis_err1_hresp", {31'd0, bus.hresp},     32'd1);
        chk("mis_err1_hrdy",  {31'd0, bus.hreadyout}, 32'd0);
        step();
        chk("mis_err2_req",   {31'd0, bus.mem_req},   32'd0);
        chk("mis_err2_hresp", {31'd0, bus.hresp},     32'd1);
        chk("mis_err2_hrdy",  {31'd0, bus.hreadyout}, 32'd1);
        step();
        chk("mis_idle_hresp", {31'd0, bus.hresp},     32'd0);
        chk("mis_idle_req",   {31'd0, bus.mem_req},   32'd0);

        // ---- oversized hsize 011 always errors ----
        ahb(1'b1, 2'b10, 1'b0, 3'b011, 32'h0);
        step();
        ahb_idle(); #1;
        chk("size3_hresp", {31'd0, bus.hresp},   32'd1);
        chk("size3_req",   {31'd0, bus.mem_req}, 32'd0);
        repeat (2) step();

        // ---- misaligned word 0x102, ERR_ON_MISALIGN = 0 ----
        bus2.hsel = 1'b1; bus2.htrans = 2'b10; bus2.hsize = 3'b010; bus2.haddr = 32'h102;
        step();
        bus2.hsel = 1'b0; bus2.htrans = 2'b00; bus2.mem_req_ack = 1'b1; #1;
        chk("nomis_req",   {31'd0, bus2.mem_req},   32'd1);
        chk("nomis_addr",  bus2.mem_addr,           32'h102);
        chk("nomis_hresp", {31'd0, bus2.hresp},     32'd0);
        step();
        bus2.mem_req_ack = 1'b0; bus2.mem_resp = 2'b01; bus2.mem_rdata = 32'h55AA_55AA;
        step();
        bus2.mem_resp = 2'b00; #1;
        chk("nomis_hrdy",   {31'd0, bus2.hreadyout}, 32'd1);
        chk("nomis_hrdata", bus2.hrdata,             32'h55AA_55AA);
        step();

        // ---- memory error, then NONSEQ accepted in ERR2 ----
        ahb(1'b1, 2'b10, 1'b1, 3'b010, 32'h300);
        step();
        ahb_idle(); mem(1'b1, 2'b00, 32'h0);
        step();
        mem(1'b0, 2'b10, 32'h0);
        step();
        mem(1'b0, 2'b00, 32'h0); #1;
        chk("merr_err1_hresp", {31'd0, bus.hresp},     32'd1);
        chk("merr_err1_hrdy",  {31'd0, bus.hreadyout}, 32'd0);
        step();
        ahb(1'b1, 2'b10, 1'b0, 3'b010, 32'h400); #1;
        chk("merr_err2_hresp", {31'd0, bus.hresp},     32'd1);
        chk("merr_err2_hrdy",  {31'd0, bus.hreadyout}, 32'd1);
        step();
        ahb_idle(); mem(1'b1, 2'b00, 32'h0); #1;
        chk("merr_next_req",   {31'd0, bus.mem_req}, 32'd1);
        chk("merr_next_addr",  bus.mem_addr,         32'h400);
        chk("merr_next_hresp", {31'd0, bus.hresp},   32'd0);
        step();
        // mem_resp = 11 must also be an error
        mem(1'b0, 2'b11, 32'h0);
        step();
        mem(1'b0, 2'b00, 32'h0); #1;
        chk("resp11_hresp", {31'd0, bus.hresp},     32'd1);
        chk("resp11_hrdy",  {31'd0, bus.hreadyout}, 32'd0);
        repeat (2) step();
        chk("resp11_idle",  {31'd0, bus.hresp},     32'd0);

        // ---- back-to-back reads 0x0, 0x4, 0x8 ----
        ahb(1'b1, 2'b10, 1'b0, 3'b010, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            ahb_idle(); mem(1'b1, 2'b00, 32'h0); #1;
            chk($sformatf("b2b_req_%0d", i),  {31'd0, bus.mem_req}, 32'd1);
            chk($sformatf("b2b_addr_%0d", i), bus.mem_addr,         32'(4 * i));
            step();
            mem(1'b0, 2'b01, b2b_data[i]); #1;
            chk($sformatf("b2b_wait_%0d", i), {31'd0, bus.hreadyout}, 32'd0);
            step();
            mem(1'b0, 2'b00, 32'h0);
            if (i < 2) ahb(1'b1, 2'b10, 1'b0, 3'b010, 32'(4 * (i + 1)));
            else       ahb(1'b0, 2'b10, 1'b0, 3'b010, 32'hC);   // hsel = 0
            #1;
            chk($sformatf("b2b_done_%0d", i),  {31'd0, bus.hreadyout}, 32'd1);
            chk($sformatf("b2b_rdata_%0d", i), bus.hrdata,             b2b_data[i]);
        end
        step();
        ahb(1'b1, 2'b01, 1'b0, 3'b010, 32'h10); #1;   // BUSY
        chk("hsel0_no_req", {31'd0, bus.mem_req},   32'd0);
        chk("hsel0_hrdy",   {31'd0, bus.hreadyout}, 32'd1);
        step();
        ahb_idle(); #1;
        chk("busy_no_req",  {31'd0, bus.mem_req},   32'd0);
        chk("busy_hrdy",    {31'd0, bus.hreadyout}, 32'd1);
        step();

        // ---- reset asserted while in RESP ----
        ahb(1'b1, 2'b10, 1'b0, 3'b010, 32'h500);
        step();
        ahb_idle(); mem(1'b1, 2'b00, 32'h0);
        step();
        mem(1'b0, 2'b00, 32'h0); #1;
        chk("rst_pre_hrdy", {31'd0, bus.hreadyout}, 32'd0);
        rst_n = 1'b0; #1;
        chk("arst_hrdy",    {31'd0, bus.hreadyout}, 32'd1);
        chk("arst_mem_req", {31'd0, bus.mem_req},   32'd0);
        chk("arst_hrdata",  bus.hrdata,             32'h0);
        step();
        rst_n = 1'b1;
        mem(1'b0, 2'b01, 32'h0777_0777);
        step();
        mem(1'b0, 2'b00, 32'h0); #1;
        chk("late_resp_hrdata", bus.hrdata,             32'h0);
        chk("late_resp_hrdy",   {31'd0, bus.hreadyout}, 32'd1);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/scr1_ahb_mem_slave.md
Name: scr1_ahb_mem_slave

Overview:
AHB-Lite slave (responder) that terminates AHB transfers from a bus master and converts each one into a single request on the SCR1 core-style memory interface: mem_req/mem_req_ack handshake plus a mem_resp/mem_rdata response.
It sits in front of TCM/peripheral memories, which makes it the target-side counterpart of the imem/dmem AHB master bridges.
It handles one outstanding transfer at a time, inserts wait states through hreadyout, and generates the two-cycle AHB ERROR response.

Parameters:
SCR1_AHB_WIDTH, 32, address/data width (fixed 32 in this release).
ERR_ON_MISALIGN, 1, 1 = a misaligned haddr for the given hsize returns ERROR without issuing a memory request; 0 = the request is passed through unchanged.

Ports:
clk  input  1  system clock, all logic on posedge
rst_n  input  1  asynchronous active-low reset
hsel  input  1  slave select
htrans  input  2  transfer type (IDLE 00, BUSY 01, NONSEQ 10, SEQ 11)
hwrite  input  1  1 = write
hsize  input  3  transfer size
haddr  input  32  address
hwdata  input  32  write data, valid in the data phase
hready  input  1  bus-level HREADY (muxed HREADYOUT of all slaves)
hreadyout  output  1  this slave's ready
hresp  output  1  0 = OKAY, 1 = ERROR
hrdata  output  32  read data
mem_req  output  1  memory request valid
mem_req_ack  input  1  request accepted
mem_cmd  output  1  0 = RD, 1 = WR
mem_width  output  2  00 = byte, 01 = hword, 10 = word
mem_addr  output  32  request address
mem_wdata  output  32  write data
mem_rdata  input  32  read data, valid with RDY_OK
mem_resp  input  2  00 = NOTRDY, 01 = RDY_OK, 10 = RDY_ER

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: state IDLE, hreadyout = 1, hresp = 0, hrdata = 0, mem_req = 0. All latched address/control registers are cleared to 0.
- Reset mid-operation: the state returns to IDLE immediately and mem_req deasserts asynchronously. Any in-flight memory response arriving later is ignored.
- Address-phase accept: acc = hsel & hready & htrans[1]. acc is evaluated only in IDLE, DONE and ERR2.
  - On acc, latch haddr, hwrite and hsize.
  - Bad transfer = hsize > 010, or (ERR_ON_MISALIGN and ((hsize = 001 and haddr[0]) or (hsize = 010 and haddr[1:0] != 0))).
  - Next state is ERR1 if the transfer is bad, otherwise REQ.
  - BUSY or IDLE htrans, or hsel = 0: next state is IDLE.
- States (hreadyout / hresp):
  - IDLE (1/0): see address-phase accept.
  - REQ (0/0): mem_req = 1; mem_addr, mem_cmd and mem_width come from the latched registers; mem_wdata = hwdata (combinational, since the master holds hwdata during wait states). mem_req_ack = 1 moves to RESP; otherwise stay in REQ with all request fields stable.
  - RESP (0/0): mem_req = 0. On mem_resp RDY_OK, register hrdata <= mem_rdata for reads (hrdata is held unchanged for writes) and go to DONE. On RDY_ER go to ERR1. On NOTRDY stay.
  - DONE (1/0): the data phase completes this cycle. Apply address-phase accept, so back-to-back transfers are pipelined.
  - ERR1 (0/1): go to ERR2 unconditionally.
  - ERR2 (1/1): apply address-phase accept. A master that cancelled its next transfer presents IDLE, giving next state IDLE.
- Latency: with ack and response in consecutive cycles, the minimum is 2 wait states (REQ, RESP), with completion in DONE; sustained throughput is 1 transfer per 3 cycles. A bad transfer always takes exactly 2 data-phase cycles (ERR1, ERR2) and issues no mem_req.
- mem_width mapping: hsize 000 -> 00, 001 -> 01, 010 -> 10. hsize bits above 2 are never forwarded.
- A mem_resp value of 11 is treated as RDY_ER.
- hrdata is stable from DONE until the next read completes.

Test Plan:
- Word read: NONSEQ, hsize = 010, haddr = 0x100; ack in REQ cycle 1; RDY_OK with 0xDEADBEEF in cycle 2 -> mem_req = 1 for exactly 1 cycle with mem_addr = 0x100, mem_cmd = 0, mem_width = 10; hreadyout low in cycles 1–2; cycle 3 hreadyout = 1, hresp = 0, hrdata = 0xDEADBEEF.
- Byte write with 3-cycle ack stall: haddr = 0x203, hwdata = 0x000000A5 -> mem_req held for 4 cycles with mem_addr = 0x203, mem_width = 00, mem_wdata = 0xA5 stable throughout; completes OKAY; hrdata unchanged.
- Misaligned word, haddr = 0x102, ERR_ON_MISALIGN = 1 -> no mem_req; hresp = 1 for 2 cycles with hreadyout = 0 then 1. Repeat with the parameter set to 0 -> normal request issued at 0x102.
- Memory error: RDY_ER returned in RESP -> ERR1/ERR2 sequence. A NONSEQ presented during ERR2 is accepted, and mem_req is issued the next cycle.
- Back-to-back: three NONSEQ reads to 0x0, 0x4, 0x8, each presented while the previous is in DONE -> three mem_req pulses, completions every 3 cycles, hrdata values match in order. An hsel = 0 cycle and a BUSY cycle in between do not start a transfer.
- rst_n asserted in RESP -> hreadyout = 1 and mem_req = 0 immediately. A late RDY_OK after reset release does not change hrdata (remains 0).
